// File: rtl/beam_window_integrator.sv
// Beam window integrator: per-cycle ADC charge accumulation, sliding-window sum
// over the last L cycle charges, and a latched window-limit interlock.
module beam_window_integrator #(
  parameter int unsigned DATA_WIDTH = 14,
  parameter int unsigned CYC_WIDTH  = 23,
  parameter int unsigned WIN_MAX    = 64,
  parameter int unsigned SUM_WIDTH  = CYC_WIDTH + $clog2(WIN_MAX)
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_sample_valid,
  input  logic [DATA_WIDTH-1:0]      i_sample,
  input  logic                       i_cycle_end,
  input  logic [$clog2(WIN_MAX):0]   i_win_len,
  input  logic                       i_win_clr,
  input  logic [SUM_WIDTH-1:0]       i_limit,
  input  logic                       i_intlk_clr,
  output logic [CYC_WIDTH-1:0]       o_cycle_charge,
  output logic                       o_cycle_sat,
  output logic [SUM_WIDTH-1:0]       o_win_sum,
  output logic [$clog2(WIN_MAX):0]   o_win_cnt,
  output logic                       o_sum_valid,
  output logic                       o_overrun,
  output logic                       o_interlock
);

  localparam int unsigned PW = $clog2(WIN_MAX);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned AW = CYC_WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_UPD,
    S_CHK
  } state_e;

  state_e state_q, state_d;

  logic [CYC_WIDTH-1:0] acc_q, acc_d;
  logic [CYC_WIDTH-1:0] hold_q, hold_d;
  logic [SUM_WIDTH-1:0] sum_q, sum_d;
  logic [LW-1:0]        cnt_q, cnt_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [CYC_WIDTH-1:0] charge_q, charge_d;
  logic                 sat_q, sat_d;
  logic                 ovr_q, ovr_d;
  logic                 intlk_q, intlk_d;
  logic [LW-1:0]        len_q, len_d;
  logic                 len_load_q;

  logic [CYC_WIDTH-1:0] mem [WIN_MAX];
  logic [CYC_WIDTH-1:0] oldest_q;

  logic                 rd_en, upd_en, chk_en;
  logic [AW-1:0]        acc_add, acc_sum;
  logic                 acc_sat;
  logic [CYC_WIDTH-1:0] acc_next;
  logic [LW-1:0]        len_req;
  logic                 ptr_wrap;

  // Requested window depth, with 0 promoted to 1 and oversize clamped.
  always_comb begin
    len_req = i_win_len;
    if (i_win_len == '0) begin
      len_req = LW'(1);
    end else if (i_win_len > LW'(WIN_MAX)) begin
      len_req = LW'(WIN_MAX);
    end
  end

  always_comb begin
    acc_add  = i_sample_valid ? AW'(i_sample) : '0;
    acc_sum  = {1'b0, acc_q} + acc_add;
    acc_sat  = acc_sum[CYC_WIDTH];
    acc_next = acc_sat ? '1 : acc_sum[CYC_WIDTH-1:0];
  end

  assign ptr_wrap = (LW'(wr_ptr_q) + LW'(1)) == len_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (i_win_clr) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (i_cycle_end) state_d = S_RD;
        S_RD:    state_d = S_UPD;
        S_UPD:   state_d = S_CHK;
        S_CHK:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // A clear abandons any in-flight update, including the CHK pulse itself.
  always_comb begin
    rd_en  = 1'b0;
    upd_en = 1'b0;
    chk_en = 1'b0;
    if (!i_win_clr) begin
      case (state_q)
        S_RD:    rd_en  = 1'b1;
        S_UPD:   upd_en = 1'b1;
        S_CHK:   chk_en = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (upd_en) begin
      mem[wr_ptr_q] <= hold_q;
    end
    if (rd_en) begin
      oldest_q <= mem[wr_ptr_q];
    end
  end

  always_comb begin
    acc_d    = acc_q;
    hold_d   = hold_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    charge_d = charge_q;
    sat_d    = sat_q;
    ovr_d    = ovr_q;
    intlk_d  = intlk_q;
    len_d    = len_q;

    if (len_load_q || i_win_clr) begin
      len_d = len_req;
    end

    if (i_win_clr) begin
      acc_d    = '0;
      hold_d   = '0;
      sum_d    = '0;
      cnt_d    = '0;
      wr_ptr_d = '0;
      charge_d = '0;
      sat_d    = 1'b0;
      ovr_d    = 1'b0;
    end else begin
      if (acc_sat) begin
        sat_d = 1'b1;
      end

      // The ending cycle includes a sample strobed in the same clock.
      if (i_cycle_end) begin
        acc_d = '0;
        if (state_q == S_IDLE) begin
          hold_d = acc_next;
        end else begin
          ovr_d = 1'b1;
        end
      end else begin
        acc_d = acc_next;
      end

      if (upd_en) begin
        if (cnt_q == len_q) begin
          sum_d = sum_q + SUM_WIDTH'(hold_q) - SUM_WIDTH'(oldest_q);
        end else begin
          sum_d = sum_q + SUM_WIDTH'(hold_q);
          cnt_d = cnt_q + LW'(1);
        end
        wr_ptr_d = ptr_wrap ? '0 : wr_ptr_q + PW'(1);
        charge_d = hold_q;
      end

      if (i_intlk_clr) begin
        intlk_d = 1'b0;
      end
      if (chk_en && (i_limit != '0) && (sum_q > i_limit)) begin
        intlk_d = 1'b1;
      end
    end
  end

  // len_load_q lets the first clock after reset release capture i_win_len.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc_q      <= '0;
      hold_q     <= '0;
      sum_q      <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      charge_q   <= '0;
      sat_q      <= 1'b0;
      ovr_q      <= 1'b0;
      intlk_q    <= 1'b0;
      len_q      <= LW'(1);
      len_load_q <= 1'b1;
    end else begin
      acc_q      <= acc_d;
      hold_q     <= hold_d;
      sum_q      <= sum_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      charge_q   <= charge_d;
      sat_q      <= sat_d;
      ovr_q      <= ovr_d;
      intlk_q    <= intlk_d;
      len_q      <= len_d;
      len_load_q <= 1'b0;
    end
  end

  assign o_cycle_charge = charge_q;
  assign o_cycle_sat    = sat_q;
  assign o_win_sum      = sum_q;
  assign o_win_cnt      = cnt_q;
  assign o_sum_valid    = chk_en;
  assign o_overrun      = ovr_q;
  assign o_interlock    = intlk_q;

endmodule

// File: tb/tb_beam_window_integrator.sv
// Directed testbench for beam_window_integrator: window fill/slide, interlock,
// saturation, overrun, clear, depth clamping and asynchronous reset.
module tb_beam_window_integrator;

  localparam int DW = 14;
  localparam int CW = 23;
  localparam int WM = 64;
  localparam int SW = 29;
  localparam int LW = 7;

  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_sample_valid = 1'b0;
  logic [DW-1:0] i_sample = '0;
  logic          i_cycle_end = 1'b0;
  logic [LW-1:0] i_win_len = 7'd4;
  logic          i_win_clr = 1'b0;
  logic [SW-1:0] i_limit = '0;
  logic          i_intlk_clr = 1'b0;
  logic [CW-1:0] o_cycle_charge;
  logic          o_cycle_sat;
  logic [SW-1:0] o_win_sum;
  logic [LW-1:0] o_win_cnt;
  logic          o_sum_valid;
  logic          o_overrun;
  logic          o_interlock;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  beam_window_integrator #(
    .DATA_WIDTH(DW),
    .CYC_WIDTH (CW),
    .WIN_MAX   (WM),
    .SUM_WIDTH (SW)
  ) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_sample_valid(i_sample_valid),
    .i_sample      (i_sample),
    .i_cycle_end   (i_cycle_end),
    .i_win_len     (i_win_len),
    .i_win_clr     (i_win_clr),
    .i_limit       (i_limit),
    .i_intlk_clr   (i_intlk_clr),
    .o_cycle_charge(o_cycle_charge),
    .o_cycle_sat   (o_cycle_sat),
    .o_win_sum     (o_win_sum),
    .o_win_cnt     (o_win_cnt),
    .o_sum_valid   (o_sum_valid),
    .o_overrun     (o_overrun),
    .o_interlock   (o_interlock)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives n samples then a cycle_end; returns clocks until o_sum_valid (-1 on timeout).
  task automatic do_cycle(input int n, input int val, input bit last_same, output int lat);
    int pre;
    pre = last_same ? n - 1 : n;
    for (int i = 0; i < pre; i++) begin
      i_sample_valid = 1'b1;
      i_sample = DW'(val);
      tick();
    end
    i_sample_valid = last_same;
    i_sample = DW'(val);
    i_cycle_end = 1'b1;
    tick();
    i_cycle_end = 1'b0;
    i_sample_valid = 1'b0;
    lat = -1;
    for (int c = 1; c <= 8 && lat < 0; c++) begin
      if (o_sum_valid === 1'b1) lat = c;
      else tick();
    end
  endtask

  task automatic do_clr(input int len);
    i_win_len = LW'(len);
    i_win_clr = 1'b1;
    tick();
    i_win_clr = 1'b0;
    tick();
  endtask

  task automatic pulse_intlk_clr();
    i_intlk_clr = 1'b1;
    tick();
    i_intlk_clr = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    i_win_len = 7'd4;
    repeat (3) tick();
    checks++;
    if ({o_cycle_charge, o_win_sum, o_win_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_data charge=%0d sum=%0d cnt=%0d exp=0", o_cycle_charge, o_win_sum, o_win_cnt);
    end
    checks++;
    if ({o_cycle_sat, o_sum_valid, o_overrun, o_interlock} !== 4'b0) begin
      failures++;
      $display("FAIL reset_flags sat=%b sv=%b ovr=%b il=%b exp=0", o_cycle_sat, o_sum_valid, o_overrun, o_interlock);
    end
    i_rst = 1'b0;
    tick();
  endtask

  task automatic test_window_fill();
    int lat;
    for (int k = 1; k <= 4; k++) begin
      do_cycle(10, 100, 1'b0, lat);
      if (k == 1) i_win_len = 7'd2;
      checks++;
      if (lat !== 3) begin
        failures++;
        $display("FAIL fill_lat[%0d] got=%0d exp=3", k, lat);
      end
      checks++;
      if (o_win_sum !== SW'(1000 * k) || o_win_cnt !== LW'(k) || o_cycle_charge !== CW'(1000)) begin
        failures++;
        $display("FAIL fill[%0d] sum=%0d cnt=%0d charge=%0d exp sum=%0d cnt=%0d charge=1000",
                 k, o_win_sum, o_win_cnt, o_cycle_charge, 1000 * k, k);
      end
    end
    do_cycle(10, 200, 1'b0, lat);
    checks++;
    if (lat !== 3 || o_win_sum !== SW'(5000) || o_win_cnt !== LW'(4) || o_cycle_charge !== CW'(2000)) begin
      failures++;
      $display("FAIL slide lat=%0d sum=%0d cnt=%0d charge=%0d exp lat=3 sum=5000 cnt=4 charge=2000",
               lat, o_win_sum, o_win_cnt, o_cycle_charge);
    end
    tick();
  endtask

  task automatic test_interlock();
    int lat;
    do_clr(4);
    i_limit = SW'(2500);
    for (int k = 1; k <= 3; k++) begin
      do_cycle(10, 100, 1'b0, lat);
      checks++;
      if (lat !== 3 || o_win_sum !== SW'(1000 * k) || o_interlock !== 1'b0) begin
        failures++;
        $display("FAIL intlk_pre[%0d] lat=%0d sum=%0d il=%b exp lat=3 sum=%0d il=0", k, lat, o_win_sum, o_interlock, 1000 * k);
      end
    end
    pulse_intlk_clr();
    checks++;
    if (o_interlock !== 1'b1) begin
      failures++;
      $display("FAIL intlk_set_wins got=%b exp=1", o_interlock);
    end
    repeat (2) tick();
    pulse_intlk_clr();
    checks++;
    if (o_interlock !== 1'b0 || o_win_sum !== SW'(3000)) begin
      failures++;
      $display("FAIL intlk_clear il=%b sum=%0d exp il=0 sum=3000", o_interlock, o_win_sum);
    end
    do_cycle(10, 100, 1'b0, lat);
    tick();
    checks++;
    if (o_interlock !== 1'b1 || o_win_sum !== SW'(4000)) begin
      failures++;
      $display("FAIL intlk_reset il=%b sum=%0d exp il=1 sum=4000", o_interlock, o_win_sum);
    end
    do_clr(1);
    checks++;
    if (o_interlock !== 1'b1 || o_win_sum !== '0) begin
      failures++;
      $display("FAIL intlk_winclr il=%b sum=%0d exp il=1 sum=0", o_interlock, o_win_sum);
    end
    pulse_intlk_clr();
    i_limit = SW'(1000);
    do_cycle(10, 100, 1'b0, lat);
    tick();
    checks++;
    if (o_interlock !== 1'b0 || o_win_sum !== SW'(1000)) begin
      failures++;
      $display("FAIL intlk_equal il=%b sum=%0d exp il=0 sum=1000", o_interlock, o_win_sum);
    end
    i_limit = '0;
    do_cycle(10, 500, 1'b0, lat);
    tick();
    checks++;
    if (o_interlock !== 1'b0 || o_win_sum !== SW'(5000)) begin
      failures++;
      $display("FAIL intlk_disabled il=%b sum=%0d exp il=0 sum=5000", o_interlock, o_win_sum);
    end
    i_limit = SW'(4999);
    do_cycle(10, 500, 1'b0, lat);
    tick();
    checks++;
    if (o_interlock !== 1'b1 || o_win_sum !== SW'(5000) || o_win_cnt !== LW'(1)) begin
      failures++;
      $display("FAIL intlk_above il=%b sum=%0d cnt=%0d exp il=1 sum=5000 cnt=1", o_interlock, o_win_sum, o_win_cnt);
    end
    i_limit = '0;
    pulse_intlk_clr();
  endtask

  task automatic test_saturation();
    int lat;
    do_clr(4);
    checks++;
    if (o_cycle_sat !== 1'b0 || o_interlock !== 1'b0) begin
      failures++;
      $display("FAIL sat_pre sat=%b il=%b exp 0 0", o_cycle_sat, o_interlock);
    end
    do_cycle(600, 16383, 1'b0, lat);
    checks++;
    if (lat !== 3 || o_cycle_charge !== CW'(8388607) || o_cycle_sat !== 1'b1 || o_win_sum !== SW'(8388607)) begin
      failures++;
      $display("FAIL sat lat=%0d charge=%0d sat=%b sum=%0d exp lat=3 charge=8388607 sat=1 sum=8388607",
               lat, o_cycle_charge, o_cycle_sat, o_win_sum);
    end
    do_cycle(5, 100, 1'b1, lat);
    checks++;
    if (lat !== 3 || o_cycle_charge !== CW'(500) || o_win_sum !== SW'(8389107) || o_win_cnt !== LW'(2) || o_cycle_sat !== 1'b1) begin
      failures++;
      $display("FAIL same_clk lat=%0d charge=%0d sum=%0d cnt=%0d sat=%b exp lat=3 charge=500 sum=8389107 cnt=2 sat=1",
               lat, o_cycle_charge, o_win_sum, o_win_cnt, o_cycle_sat);
    end
    tick();
  endtask

  task automatic test_overrun();
    int lat;
    int pulses;
    do_clr(4);
    checks++;
    if (o_cycle_sat !== 1'b0 || o_overrun !== 1'b0 || o_win_sum !== '0 || o_win_cnt !== '0 || o_cycle_charge !== '0) begin
      failures++;
      $display("FAIL clr4 sat=%b ovr=%b sum=%0d cnt=%0d charge=%0d exp all 0",
               o_cycle_sat, o_overrun, o_win_sum, o_win_cnt, o_cycle_charge);
    end
    for (int i = 0; i < 10; i++) begin
      i_sample_valid = 1'b1;
      i_sample = DW'(100);
      tick();
    end
    i_sample_valid = 1'b0;
    i_cycle_end = 1'b1;
    tick();
    i_cycle_end = 1'b0;
    i_sample_valid = 1'b1;
    i_sample = DW'(50);
    tick();
    i_sample_valid = 1'b0;
    i_cycle_end = 1'b1;
    tick();
    i_cycle_end = 1'b0;
    checks++;
    if (o_sum_valid !== 1'b1 || o_win_sum !== SW'(1000) || o_win_cnt !== LW'(1) || o_overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun sv=%b sum=%0d cnt=%0d ovr=%b exp sv=1 sum=1000 cnt=1 ovr=1",
               o_sum_valid, o_win_sum, o_win_cnt, o_overrun);
    end
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (o_sum_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0 || o_win_cnt !== LW'(1)) begin
      failures++;
      $display("FAIL overrun_drop pulses=%0d cnt=%0d exp pulses=0 cnt=1", pulses, o_win_cnt);
    end
    do_clr(0);
    checks++;
    if (o_overrun !== 1'b0 || o_win_sum !== '0 || o_win_cnt !== '0 || o_cycle_charge !== '0) begin
      failures++;
      $display("FAIL clr0 ovr=%b sum=%0d cnt=%0d charge=%0d exp all 0", o_overrun, o_win_sum, o_win_cnt, o_cycle_charge);
    end
    do_cycle(5, 100, 1'b0, lat);
    checks++;
    if (lat !== 3 || o_win_sum !== SW'(500) || o_win_cnt !== LW'(1)) begin
      failures++;
      $display("FAIL len1_a lat=%0d sum=%0d cnt=%0d exp lat=3 sum=500 cnt=1", lat, o_win_sum, o_win_cnt);
    end
    do_cycle(5, 60, 1'b0, lat);
    checks++;
    if (lat !== 3 || o_win_sum !== SW'(300) || o_win_cnt !== LW'(1)) begin
      failures++;
      $display("FAIL len1_b lat=%0d sum=%0d cnt=%0d exp lat=3 sum=300 cnt=1", lat, o_win_sum, o_win_cnt);
    end
    tick();
  endtask

  task automatic test_clamp();
    int lat;
    do_clr(127);
    for (int k = 0; k < 65; k++) begin
      do_cycle(1, k + 1, 1'b0, lat);
      if (k == 63) begin
        checks++;
        if (o_win_sum !== SW'(2080) || o_win_cnt !== LW'(64)) begin
          failures++;
          $display("FAIL clamp_full sum=%0d cnt=%0d exp sum=2080 cnt=64", o_win_sum, o_win_cnt);
        end
      end
    end
    checks++;
    if (lat !== 3 || o_win_sum !== SW'(2144) || o_win_cnt !== LW'(64)) begin
      failures++;
      $display("FAIL clamp_slide lat=%0d sum=%0d cnt=%0d exp lat=3 sum=2144 cnt=64", lat, o_win_sum, o_win_cnt);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int lat;
    do_clr(4);
    i_limit = SW'(100);
    do_cycle(3, 100, 1'b0, lat);
    tick();
    checks++;
    if (o_win_sum !== SW'(300) || o_interlock !== 1'b1) begin
      failures++;
      $display("FAIL rst_setup sum=%0d il=%b exp sum=300 il=1", o_win_sum, o_interlock);
    end
    i_limit = '0;
    for (int i = 0; i < 5; i++) begin
      i_sample_valid = 1'b1;
      i_sample = DW'(100);
      tick();
    end
    i_sample_valid = 1'b0;
    i_cycle_end = 1'b1;
    tick();
    i_cycle_end = 1'b0;
    tick();
    i_rst = 1'b1;
    #1;
    checks++;
    if ({o_cycle_charge, o_win_sum, o_win_cnt, o_cycle_sat, o_sum_valid, o_overrun, o_interlock} !== '0) begin
      failures++;
      $display("FAIL rst_mid charge=%0d sum=%0d cnt=%0d sat=%b sv=%b ovr=%b il=%b exp all 0",
               o_cycle_charge, o_win_sum, o_win_cnt, o_cycle_sat, o_sum_valid, o_overrun, o_interlock);
    end
    i_win_len = 7'd4;
    repeat (2) tick();
    i_rst = 1'b0;
    tick();
    do_cycle(7, 100, 1'b0, lat);
    checks++;
    if (lat !== 3 || o_win_sum !== SW'(700) || o_win_cnt !== LW'(1) || o_cycle_charge !== CW'(700)) begin
      failures++;
      $display("FAIL rst_after lat=%0d sum=%0d cnt=%0d charge=%0d exp lat=3 sum=700 cnt=1 charge=700",
               lat, o_win_sum, o_win_cnt, o_cycle_charge);
    end
    tick();
  endtask

  initial begin
    #1;
    test_reset();
    test_window_fill();
    test_interlock();
    test_saturation();
    test_overrun();
    test_clamp();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
